uart_rx_ext: RTL and testbench

UART_RX_EXT -- requirements
Module: uart_rx_ext

---
 rtl/uart_rx_ext.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext.sv
// uart_rx_ext -- oversampling UART receiver with optional parity, 1 or 2 stop
// bits, a one-word output holding register with valid/ready handshake, and
// sticky overrun reporting.
//
// Ports
//   i_clk        : single clock, all state on its rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_tick       : one-cycle strobe at OVERSAMPLE x baud rate
//   i_rx         : asynchronous serial line, idle high
//   o_rx_data    : received word, LSB received first
//   o_rx_valid   : o_rx_data and the error flags are valid
//   i_rx_ready   : consumer takes the word when high together with o_rx_valid
//   o_parity_err : parity mismatch for the held word (0 when parity disabled)
//   o_frame_err  : a stop bit was sampled low for the held word
//   o_overrun    : an unaccepted word was overwritten (sticky until a handshake)
module uart_rx_ext #(
    parameter int NB_DATA    = 8,
    parameter int NB_STOP    = 1,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_valid,
    input  logic               i_rx_ready,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_overrun
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(NB_DATA);

    localparam logic [TICK_W-1:0] TICK_HALF      = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST      = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST_DATA  = BIT_W'(NB_DATA - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST_STOP  = BIT_W'(NB_STOP - 1);
    localparam logic              PARITY_ODD_BIT = (PARITY_ODD != 0);
    localparam logic              PARITY_ON      = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               state_reg, state_next;
    logic [TICK_W-1:0]    tick_reg, tick_next;
    logic [BIT_W-1:0]     bit_reg, bit_next;
    logic [NB_DATA-1:0]   shift_reg, shift_next;
    logic                 par_err_reg, par_err_next;
    logic                 frm_err_reg, frm_err_next;
    logic                 done;
    logic [1:0]           sync_reg;
    logic                 rx_s;
    logic                 accept;

    // Two-flop synchronizer; resets to the idle (high) line level so that
    // reset release never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], i_rx};
        end
    end

    assign rx_s = sync_reg[1];

    // Receive state register and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= ST_IDLE;
            tick_reg    <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
            par_err_reg <= 1'b0;
            frm_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            bit_reg     <= bit_next;
            shift_reg   <= shift_next;
            par_err_reg <= par_err_next;
            frm_err_reg <= frm_err_next;
        end
    end

    // Next-state logic. Every counter advance is gated by i_tick; once the
    // start bit is confirmed at its midpoint, each later sample lands a full
    // bit period later, i.e. mid-bit.
    always_comb begin
        state_next   = state_reg;
        tick_next    = tick_reg;
        bit_next     = bit_reg;
        shift_next   = shift_reg;
        par_err_next = par_err_reg;
        frm_err_next = frm_err_reg;
        done         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_START;
                    tick_next  = '0;
                end
            end

            ST_START: begin
                if (i_tick) begin
                    if (tick_reg == TICK_HALF) begin
                        if (rx_s) begin
                            // Line went back high before mid start bit: glitch.
                            state_next = ST_IDLE;
                        end else begin
                            state_next   = ST_DATA;
                            tick_next    = '0;
                            bit_next     = '0;
                            par_err_next = 1'b0;
                            frm_err_next = 1'b0;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (i_tick) begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next  = '0;
                        shift_next = {rx_s, shift_reg[NB_DATA-1:1]};
                        if (bit_reg == BIT_LAST_DATA) begin
                            bit_next   = '0;
                            state_next = PARITY_ON ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_next = bit_reg + 1'b1;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                if (i_tick) begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next    = '0;
                        bit_next     = '0;
                        par_err_next = (^shift_reg) ^ rx_s ^ PARITY_ODD_BIT;
                        state_next   = ST_STOP;
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end

            ST_STOP: begin
                if (i_tick) begin
                    if (tick_reg == TICK_LAST) begin
                        tick_next = '0;
                        if (!rx_s) begin
                            frm_err_next = 1'b1;
                        end
                        if (bit_reg == BIT_LAST_STOP) begin
                            // Frame ends at the middle of the last stop bit.
                            bit_next   = '0;
                            state_next = ST_IDLE;
                            done       = 1'b1;
                        end else begin
                            bit_next = bit_reg + 1'b1;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign accept = o_rx_valid && i_rx_ready;

    // Output holding register. A completion always loads; overrun is raised
    // only when a held word is replaced without being taken, and a handshake
    // without a coincident completion clears both valid and overrun.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else if (done) begin
            o_rx_data    <= shift_reg;
            o_parity_err <= par_err_next & PARITY_ON;
            o_frame_err  <= frm_err_next;
            o_rx_valid   <= 1'b1;
            if (o_rx_valid && !i_rx_ready) begin
                o_overrun <= 1'b1;
            end
        end else if (accept) begin
            o_rx_valid <= 1'b0;
            o_overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext. Three instances cover 8N1, 8E1 and
// 8N2 framing; a scoreboard queue holds the words expected at each handshake.
module tb_uart_rx_ext;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [1:0] tick_div = 2'd0;
    logic [2:0] rx;
    logic [2:0] ready;
    logic [2:0] valid;
    logic [2:0] perr;
    logic [2:0] ferr;
    logic [2:0] ovr;
    logic [7:0] rx_data [3];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_start  = 0;
    int t_valid [3];

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    exp_t exp_q [$];

    always #5 clk = ~clk;

    // One baud tick every 4 clocks.
    always @(posedge clk) begin
        tick_div <= tick_div + 2'd1;
        cyc      <= cyc + 1;
    end
    assign tick = (tick_div == 2'd3);

    uart_rx_ext #(.NB_DATA(8), .NB_STOP(1), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx[0]),
        .o_rx_data(rx_data[0]), .o_rx_valid(valid[0]), .i_rx_ready(ready[0]),
        .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_overrun(ovr[0])
    );

    uart_rx_ext #(.NB_DATA(8), .NB_STOP(1), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx[1]),
        .o_rx_data(rx_data[1]), .o_rx_valid(valid[1]), .i_rx_ready(ready[1]),
        .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_overrun(ovr[1])
    );

    uart_rx_ext #(.NB_DATA(8), .NB_STOP(2), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx(rx[2]),
        .o_rx_data(rx_data[2]), .o_rx_valid(valid[2]), .i_rx_ready(ready[2]),
        .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .o_overrun(ovr[2])
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int d, input logic [7:0] data, input logic pe,
                            input logic fe, input logic ov);
        exp_t e;
        e.dut  = d;
        e.data = data;
        e.pe   = pe;
        e.fe   = fe;
        e.ov   = ov;
        exp_q.push_back(e);
    endtask

    // Drive one bit for nticks baud ticks (4 clocks per tick).
    task automatic send_bit(input int d, input logic v, input int nticks);
        @(posedge clk);
        #1;
        rx[d] = v;
        repeat (nticks * 4 - 1) @(posedge clk);
    endtask

    // A low last stop bit is held low only for 12 ticks so the receiver's
    // glitch filter rejects the tail instead of seeing a new start bit.
    task automatic send_frame(input int d, input logic [7:0] data, input int par_en,
                              input logic par_bit, input int nstop, input logic last_stop);
        @(posedge clk);
        #1;
        rx[d]   = 1'b0;
        t_start = cyc;
        repeat (63) @(posedge clk);
        for (int i = 0; i < 8; i++) send_bit(d, data[i], 16);
        if (par_en != 0) send_bit(d, par_bit, 16);
        for (int s = 0; s < nstop; s++) begin
            if (s == nstop - 1 && !last_stop) begin
                send_bit(d, 1'b0, 12);
                send_bit(d, 1'b1, 4);
            end else begin
                send_bit(d, 1'b1, 16);
            end
        end
        send_bit(d, 1'b1, 32);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        check_val("sb_drain_left", exp_q.size(), 0);
    endtask

    // Scoreboard: every accepted handshake pops and compares one entry.
    task automatic monitor();
        logic [2:0] vprev;
        exp_t       e;
        vprev = 3'b000;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (valid[d] && !vprev[d]) t_valid[d] = cyc;
                if (valid[d] && ready[d]) begin
                    if (exp_q.size() == 0) begin
                        check_val("sb_unexpected_word", {24'd0, rx_data[d]}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("sb_dut", d, e.dut);
                        check_val("sb_data", {24'd0, rx_data[d]}, {24'd0, e.data});
                        check_val("sb_parity_err", {31'd0, perr[d]}, {31'd0, e.pe});
                        check_val("sb_frame_err", {31'd0, ferr[d]}, {31'd0, e.fe});
                        check_val("sb_overrun", {31'd0, ovr[d]}, {31'd0, e.ov});
                        $display("word dut%0d data=0x%02h pe=%0b fe=%0b ov=%0b", d,
                                 rx_data[d], perr[d], ferr[d], ovr[d]);
                    end
                end
            end
            vprev = valid;
        end
    endtask

    int         lat;
    logic       any_valid;
    logic [7:0] pdata;
    logic       pbit;

    initial begin
        rst_n = 1'b0;
        rx    = 3'b111;
        ready = 3'b111;
        fork
            monitor();
        join_none

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("reset_valid", {29'd0, valid}, 32'd0);
        check_val("reset_data0", {24'd0, rx_data[0]}, 32'd0);
        check_val("reset_flags", {23'd0, perr, ferr, ovr}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);

        // 8N1 0xA5, plus latency from start edge to valid.
        push_exp(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'hA5, 0, 1'b0, 1, 1'b1);
        wait_drain();
        lat = t_valid[0] - t_start;
        $display("latency dut0 = %0d cycles", lat);
        // 8 ticks to mid start + 9 bits x 16 ticks = 152 ticks x 4 clocks,
        // plus synchronizer and tick-phase slack.
        check_val("latency_window", {31'd0, (lat >= 600 && lat <= 622)}, 32'd1);

        // Even parity: model computes the expected error from data and parity bit.
        for (int k = 0; k < 3; k++) begin
            pdata = (k == 2) ? 8'h07 : 8'h03;
            pbit  = (k == 1) ? 1'b0 : 1'b1;
            push_exp(1, pdata, (^pdata) ^ pbit, 1'b0, 1'b0);
            send_frame(1, pdata, 1, pbit, 1, 1'b1);
        end
        wait_drain();

        // Two stop bits: second stop low, then a clean frame.
        push_exp(2, 8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(2, 8'h3C, 0, 1'b0, 2, 1'b0);
        push_exp(2, 8'hC3, 1'b0, 1'b0, 1'b0);
        send_frame(2, 8'hC3, 0, 1'b0, 2, 1'b1);
        wait_drain();

        // 4-tick low glitch on the idle line must not produce a word.
        any_valid = 1'b0;
        send_bit(0, 1'b0, 4);
        send_bit(0, 1'b1, 4);
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            any_valid = any_valid | valid[0];
        end
        check_val("glitch_no_valid", {31'd0, any_valid}, 32'd0);
        push_exp(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h5A, 0, 1'b0, 1, 1'b1);
        wait_drain();

        // Overrun: 0x11 is overwritten by 0x22 while not accepted.
        @(posedge clk);
        #1;
        ready[0] = 1'b0;
        push_exp(0, 8'h22, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h11, 0, 1'b0, 1, 1'b1);
        send_frame(0, 8'h22, 0, 1'b0, 1, 1'b1);
        @(negedge clk);
        check_val("ovr_valid_held", {31'd0, valid[0]}, 32'd1);
        check_val("ovr_data_held", {24'd0, rx_data[0]}, 32'h22);
        check_val("ovr_flag_set", {31'd0, ovr[0]}, 32'd1);
        @(posedge clk);
        #1;
        ready[0] = 1'b1;
        @(posedge clk);
        #1;
        ready[0] = 1'b0;
        @(negedge clk);
        check_val("ovr_valid_cleared", {31'd0, valid[0]}, 32'd0);
        check_val("ovr_flag_cleared", {31'd0, ovr[0]}, 32'd0);
        check_val("ovr_sb_empty", exp_q.size(), 0);

        // Reset in the middle of data bit 4 with a word held at the output.
        send_frame(0, 8'h81, 0, 1'b0, 1, 1'b1);
        @(negedge clk);
        check_val("pre_rst_valid", {31'd0, valid[0]}, 32'd1);
        check_val("pre_rst_data", {24'd0, rx_data[0]}, 32'h81);
        send_bit(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 16);
        @(posedge clk);
        #1;
        rx[0] = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", {31'd0, valid[0]}, 32'd0);
        check_val("async_rst_data", {24'd0, rx_data[0]}, 32'd0);
        check_val("async_rst_flags", {29'd0, perr[0], ferr[0], ovr[0]}, 32'd0);
        rx[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ready[0] = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            any_valid = any_valid | valid[0];
        end
        check_val("rst_no_word", {31'd0, any_valid}, 32'd0);
        push_exp(0, 8'hC3, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'hC3, 0, 1'b0, 1, 1'b1);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
